// File: rtl/demux_1_4_stream_pkg.sv
// Shared constants for the 1:4 stream demux.
//   LANES       number of output lanes
//   SEL_W       width of the lane select
//   LANE0..3    lane select encodings
package demux_1_4_stream_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  localparam lane_sel_t LANE0 = 2'd0;
  localparam lane_sel_t LANE1 = 2'd1;
  localparam lane_sel_t LANE2 = 2'd2;
  localparam lane_sel_t LANE3 = 2'd3;
endpackage

// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1:4 demux: one valid/ready input with lane select,
// four independent valid/ready outputs and per-lane delivered counters.
//   slave  : demux side (consumes in_*, produces out_*/lane_cnt/in_ready)
//   master : environment side (producer + four consumers)
interface demux_1_4_stream_if
  import demux_1_4_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]                  in_data;
  lane_sel_t                         in_sel;
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0][WIDTH-1:0]       out_data;   // lane i at [i*WIDTH +: WIDTH]
  logic [LANES-1:0]                  out_valid;
  logic [LANES-1:0]                  out_ready;
  logic [LANES-1:0][CNT_W-1:0]       lane_cnt;   // lane i at [i*CNT_W +: CNT_W]

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, lane_cnt
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, lane_cnt
  );
endinterface

// File: rtl/demux_1_4_stream_lane_buf.sv
// demux_lane_buf: single-entry lane buffer with a delivered-word counter.
//   clk, rst_n  clock, async active-low reset
//   load        write load_data into the buffer on the next edge
//   load_data   word to store
//   out_ready   consumer accepts the held word
//   out_valid   buffer holds a word
//   out_data    held word (registered)
//   cnt         number of words delivered, wraps modulo 2^CNT_W
module demux_lane_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);
  logic drain;
  assign drain = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
    end else begin
      // load wins over drain: a same-cycle drain+load keeps the lane full
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: registered 1:4 stream demultiplexer.
//   clk, rst_n  clock, async active-low reset
//   bus         demux_1_4_stream_if.slave: in_data/in_sel/in_valid/in_ready,
//               out_data/out_valid/out_ready per lane, lane_cnt per lane
// Each word goes to exactly one lane buffer chosen by in_sel; lanes stall
// independently. in_ready depends combinationally on out_ready of the
// selected lane so a full lane can be drained and refilled every cycle.
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1_4_stream_if.slave  bus
);
  logic [LANES-1:0] load;
  logic             accept;

  // evaluated from in_sel regardless of in_valid
  assign bus.in_ready = !bus.out_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    if (accept) load[bus.in_sel] = 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[i]),
      .out_valid (bus.out_valid[i]),
      .out_data  (bus.out_data[i]),
      .cnt       (bus.lane_cnt[i])
    );
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1_4_stream_if #(.WIDTH(32), .CNT_W(8)) bus ();
  demux_1_4_stream #(.WIDTH(32), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: each lane is a FIFO of words awaiting delivery
  logic [31:0] exp_q [4][$];
  bit   [3:0]  occ;
  int          cnt [4];
  bit          last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt_vec();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = cnt[i][7:0];
    return v;
  endfunction

  task automatic model_clear();
    occ = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      exp_q[i].delete();
    end
  endtask

  // One clock: check registered state, drive inputs, check in_ready, step model.
  task automatic cycle(input bit v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy);
    bit exp_rdy, acc, drn;
    @(posedge clk);
    #1;
    chk("out_valid", {60'd0, bus.out_valid}, {60'd0, occ});
    chk("lane_cnt", {32'd0, bus.lane_cnt}, {32'd0, exp_cnt_vec()});
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !occ[sel] || ordy[sel];
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    acc = v && exp_rdy;
    for (int i = 0; i < 4; i++) begin
      drn = occ[i] && ordy[i];
      if (drn) cnt[i] = (cnt[i] + 1) % 256;
      if (acc && sel == i) occ[i] = 1'b1;
      else if (drn)        occ[i] = 1'b0;
    end
    if (acc) exp_q[sel].push_back(d);
    last_acc = acc;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", {60'd0, bus.out_valid}, 64'd0);
    chk("rst lane_cnt", {32'd0, bus.lane_cnt}, 64'd0);
    chk("rst in_ready", {63'd0, bus.in_ready}, 64'd1);
    model_clear();
    #1 rst_n = 1'b1;
  endtask

  // monitor: every delivery handshake must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.out_valid[i] && bus.out_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL deliver lane%0d: got %0h expected nothing at %0t",
                       i, bus.out_data[i], $time);
            end else begin
              chk($sformatf("deliver lane%0d", i), {32'd0, bus.out_data[i]},
                  {32'd0, exp_q[i].pop_front()});
            end
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  r_sel;
    logic [31:0] r_dat;
    bit          r_v;
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'b0000;
    model_clear();
    last_acc = 1'b0;
    #2;
    chk("init out_valid", {60'd0, bus.out_valid}, 64'd0);
    chk("init lane_cnt", {32'd0, bus.lane_cnt}, 64'd0);
    chk("init in_ready", {63'd0, bus.in_ready}, 64'd1);
    #10 rst_n = 1'b1;

    // reset mid-operation discards the held word
    cycle(1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
    cycle(0, 2'd0, 32'h0, 4'b0000);
    chk("lane2 held", {32'd0, bus.out_data[2]}, {32'd0, 32'hDEAD_BEEF});
    reset_pulse();
    repeat (3) cycle(0, 2'd0, 32'h0, 4'b1111);

    // basic route to all four lanes
    for (int i = 0; i < 4; i++) cycle(1, i[1:0], 32'h11 + i, 4'b1111);
    cycle(0, 2'd0, 32'h0, 4'b1111);
    cycle(0, 2'd0, 32'h0, 4'b1111);
    chk("basic cnt", {32'd0, bus.lane_cnt}, {32'd0, 32'h01010101});

    // stalled lane1 does not block lane3
    cycle(1, 2'd1, 32'hA5, 4'b1101);
    cycle(1, 2'd1, 32'h77, 4'b1101);
    chk("stall in_ready", {63'd0, bus.in_ready}, 64'd0);
    cycle(1, 2'd3, 32'h5A, 4'b1101);
    chk("lane3 accept", {63'd0, bus.in_ready}, 64'd1);
    cycle(0, 2'd0, 32'h0, 4'b1101);
    chk("lane3 data", {32'd0, bus.out_data[3]}, {32'd0, 32'h5A});
    chk("lane1 kept", {32'd0, bus.out_data[1]}, {32'd0, 32'hA5});
    cycle(0, 2'd0, 32'h0, 4'b1111);

    // same-lane drain and reload
    cycle(1, 2'd0, 32'h1, 4'b1111);
    cycle(1, 2'd0, 32'h2, 4'b1111);
    cycle(0, 2'd0, 32'h0, 4'b0000);
    chk("b2b valid", {63'd0, bus.out_valid[0]}, 64'd1);
    chk("b2b data", {32'd0, bus.out_data[0]}, {32'd0, 32'h2});
    cycle(0, 2'd0, 32'h0, 4'b1111);

    // counter wrap on lane2
    reset_pulse();
    for (int i = 0; i < 256; i++) cycle(1, 2'd2, 32'h1000 + i, 4'b0100);
    cycle(0, 2'd0, 32'h0, 4'b0100);
    chk("cnt 255", {32'd0, bus.lane_cnt}, {32'd0, 32'h00FF0000});
    cycle(0, 2'd0, 32'h0, 4'b0100);
    chk("cnt wrap", {32'd0, bus.lane_cnt}, 64'd0);

    // spurious ready with no data
    repeat (10) cycle(0, 2'd0, 32'h0, 4'b1111);
    chk("spurious valid", {60'd0, bus.out_valid}, 64'd0);
    chk("spurious cnt", {32'd0, bus.lane_cnt}, 64'd0);

    // randomized traffic, producer holds word while stalled
    r_v = 0; r_sel = 0; r_dat = 0;
    last_acc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!(r_v && !last_acc)) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_sel = 2'($urandom_range(0, 3));
        r_dat = $urandom;
      end
      cycle(r_v, r_sel, r_dat, 4'($urandom_range(0, 15)));
    end
    repeat (3) cycle(0, 2'd0, 32'h0, 4'b1111);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drained lane%0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
Registered 1-to-4 stream demultiplexer. It is the distribution-side counterpart of the 4:1 select mux. One valid/ready input stream carries data plus a 2-bit lane select, and each word is routed into one of four independent single-entry lane buffers. Used in the datapath wherever a single producer (e.g. write-back or ALU result bus) feeds four consumers that can stall independently.

Parameters:
WIDTH, 32, data word width in bits
CNT_W, 8, width of each per-lane delivered-word counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input word
in_sel  input  2  destination lane: 00 to lane0, 01 to lane1, 10 to lane2, 11 to lane3
in_valid  input  1  input word and in_sel valid this cycle
in_ready  output  1  block accepts the input this cycle
out_data  output  4*WIDTH  lane i data on bits [i*WIDTH +: WIDTH]
out_valid  output  4  lane i holds a word
out_ready  input  4  consumer i accepts the word this cycle
lane_cnt  output  4*CNT_W  lane i delivered-word count on bits [i*CNT_W +: CNT_W]

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - All lane buffers are cleared: out_valid=4'b0000, out_data=0, lane_cnt=0.
  - Words held in a buffer when reset asserts are discarded.
  - in_ready follows its equation, so it reads 1 during reset. Inputs are ignored while rst_n=0.
- Each lane i has buffer state buf_valid[i] and buf_data[i].
  - out_valid[i]=buf_valid[i] and out_data lane i=buf_data[i], driven directly from registers.
- in_ready = !buf_valid[in_sel] | out_ready[in_sel].
  - This is a combinational path from out_ready to in_ready; it is intentional.
  - in_ready is computed from in_sel even when in_valid=0.
- Accept: in_valid & in_ready. On the next edge buf_data[in_sel] <= in_data and buf_valid[in_sel] <= 1.
- Latency: exactly 1 cycle from input accept to out_valid. Throughput is one word per clock into any lane whose consumer holds ready high.
- Drain: out_valid[i] & out_ready[i].
  - On the next edge buf_valid[i] <= 0 and lane_cnt[i] increments by 1.
  - The counter wraps modulo 2^CNT_W (255 to 0 at the default).
- Simultaneous drain and load on the same lane: buf_valid[i] stays 1, buf_data[i] takes the new word, and lane_cnt[i] still increments.
- Loading lane j while lane k (k != j) drains is fully independent. A stalled lane never blocks traffic to other lanes.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data lane i holds constant.
- in_valid=1 with in_ready=0 means the input stalls. The producer must hold in_data and in_sel stable until accepted.
- in_data is never routed to more than one lane. Unselected lane buffers are never written.
- out_ready[i] asserted while out_valid[i]=0 has no effect; lane_cnt[i] is unchanged.

Decomposition:
- Shared package: LANES=4, SEL_W=2, lane index constants LANE0..LANE3.
- Sub-module demux_lane_buf: one-entry buffer plus CNT_W counter, with ports clk, rst_n, load, load_data, out_ready, out_valid, out_data, cnt. It is instantiated 4 times.
- The top level holds only the in_sel decode and the in_ready select.

Test Plan:
1. Reset mid-operation: load lane2 with 32'hDEAD_BEEF (out_ready=0), then pulse rst_n low between edges. out_valid drops to 0000 immediately, lane_cnt=0, and the word is never delivered.
2. Basic route: out_ready=1111, send 32'h11/12/13/14 with in_sel=0,1,2,3 on consecutive cycles.
   - Each out_valid[i] pulses 1 cycle after its accept with the matching data.
   - in_ready stays 1 throughout.
   - lane_cnt for every lane ends at 1.
3. Lane stall isolation: out_ready=1101 and lane1 holds 32'hA5.
   - Sending in_sel=1 gives in_ready=0, and lane1 keeps 32'hA5.
   - Sending in_sel=3 with 32'h5A is accepted, and lane3 delivers it next cycle.
4. Same-lane back-to-back: lane0 holds 32'h1 with out_ready[0]=1, and 32'h2 arrives for lane0 in the same cycle. in_ready=1, out_valid[0] stays 1, the next-cycle out_data lane0 is 32'h2, and lane_cnt[0] increments.
5. Counter wrap: 256 deliveries on lane2 with out_ready[2]=1 take lane_cnt[2] from 255 to 0. Other lanes' counters stay 0.
6. Spurious ready: out_ready=1111 with no input for 10 cycles leaves out_valid=0000 and lane_cnt unchanged.
